ex: RTL and testbench

Execute stage of the five-stage MIPS pipeline. Consumes the decoded operation, operands and destination held in the ID/EX pipeline register, and computes the write-back value. Produces HI/LO updates and the result presented to the EX/MEM register. Owns the iterative 32-cycle divider and raises a stall request to the pipeline controller while a division is in flight.

---
 rtl/ex_pkg.sv | 58 +++++
 rtl/ex_div.sv | 123 ++++++++++++
 rtl/ex.sv | 186 ++++++++++++++++++
 tb/tb_ex.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: bus widths, aluop/alusel
// encodings, divider state encoding and a small sign helper.
package ex_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 8;
    localparam int ALU_SEL_W  = 3;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    // aluop encodings
    localparam logic [ALU_OP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [ALU_OP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [ALU_OP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [ALU_OP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [ALU_OP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [ALU_OP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [ALU_OP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [ALU_OP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [ALU_OP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [ALU_OP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [ALU_OP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [ALU_OP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [ALU_OP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [ALU_OP_W-1:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [ALU_OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALU_OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALU_OP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

    // alusel result classes
    localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP         = 3'b000;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT       = 3'b010;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_MOVE        = 3'b011;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITHMETIC  = 3'b100;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_MUL         = 3'b101;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_JUMP_BRANCH = 3'b110;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    function automatic logic [REG_W-1:0] neg_if(input logic neg, input logic [REG_W-1:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider: one quotient bit per cycle, 32 iterations,
// signed fix-up applied on the transition into DIV_END.
module ex_div
    import ex_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [REG_W-1:0]     opdata1_i,
    input  logic [REG_W-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*REG_W-1:0]   result_o,
    output logic                 ready_o
);

    div_state_e       r_state;
    div_state_e       w_next_state;
    logic [4:0]       r_cnt;
    logic [REG_W-1:0] r_quo;
    logic [REG_W-1:0] r_rem;
    logic [REG_W-1:0] r_divisor;
    logic             r_neg_quo;
    logic             r_neg_rem;

    logic [REG_W:0]   w_shifted;
    logic [REG_W:0]   w_diff;
    logic [REG_W-1:0] w_step_quo;
    logic [REG_W-1:0] w_step_rem;
    logic [REG_W-1:0] w_mag1;
    logic [REG_W-1:0] w_mag2;

    assign w_mag1 = neg_if(signed_div_i && opdata1_i[REG_W-1], opdata1_i);
    assign w_mag2 = neg_if(signed_div_i && opdata2_i[REG_W-1], opdata2_i);

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        w_shifted = {r_rem, r_quo[REG_W-1]};
        w_diff    = w_shifted - {1'b0, r_divisor};
        if (!w_diff[REG_W]) begin
            w_step_rem = w_diff[REG_W-1:0];
            w_step_quo = {r_quo[REG_W-2:0], 1'b1};
        end else begin
            w_step_rem = w_shifted[REG_W-1:0];
            w_step_quo = {r_quo[REG_W-2:0], 1'b0};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_FREE;
        else     r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DIV_FREE: begin
                if (start_i && !annul_i)
                    w_next_state = (opdata2_i == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
            end
            DIV_BY_ZERO: w_next_state = DIV_END;
            DIV_ON: begin
                if (annul_i)              w_next_state = DIV_FREE;
                else if (r_cnt == 5'd31)  w_next_state = DIV_END;
            end
            DIV_END: w_next_state = DIV_FREE;
            default: w_next_state = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_quo     <= ZERO_WORD;
            r_rem     <= ZERO_WORD;
            r_divisor <= ZERO_WORD;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (start_i && !annul_i) begin
                        r_cnt     <= '0;
                        r_quo     <= w_mag1;
                        r_rem     <= ZERO_WORD;
                        r_divisor <= w_mag2;
                        r_neg_quo <= signed_div_i && (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
                        r_neg_rem <= signed_div_i && opdata1_i[REG_W-1];
                    end
                end
                DIV_BY_ZERO: begin
                    r_quo <= ZERO_WORD;
                    r_rem <= ZERO_WORD;
                end
                DIV_ON: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_quo <= neg_if(r_neg_quo, w_step_quo);
                        r_rem <= neg_if(r_neg_rem, w_step_rem);
                    end else begin
                        r_quo <= w_step_quo;
                        r_rem <= w_step_rem;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ready_o  = DIV_RESULT_NOT_READY;
        result_o = '0;
        if (r_state == DIV_END) begin
            ready_o  = DIV_RESULT_READY;
            result_o = {r_rem, r_quo};
        end
    end

endmodule

// File: rtl/ex.sv
// MIPS execute stage: combinational result/HI-LO selection plus the iterative
// divider. Define HW_DIV_EN to build the divider; otherwise div/divu act as nop.
module ex
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [ALU_SEL_W-1:0]  alusel_i,
    input  logic [REG_W-1:0]      reg1_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      link_address_i,
    input  logic [REG_W-1:0]      hi_i,
    input  logic [REG_W-1:0]      lo_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  whilo_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  stallreq_o
);

    logic [REG_W-1:0]   w_logic;
    logic [REG_W-1:0]   w_shift;
    logic [REG_W-1:0]   w_move;
    logic [REG_W-1:0]   w_arith;
    logic [REG_W-1:0]   w_reg2_eff;
    logic [REG_W-1:0]   w_sum;
    logic               w_ovf;
    logic               w_is_sub;
    logic [2*REG_W-1:0] w_mul_a;
    logic [2*REG_W-1:0] w_mul_b;
    logic [2*REG_W-1:0] w_product;
    logic [REG_W-1:0]   w_wdata;
    logic               w_whilo;
    logic [REG_W-1:0]   w_hi;
    logic [REG_W-1:0]   w_lo;
    logic               w_stall;

    always_comb begin
        w_logic = ZERO_WORD;
        case (aluop_i)
            EXE_AND_OP: w_logic = reg1_i & reg2_i;
            EXE_OR_OP:  w_logic = reg1_i | reg2_i;
            EXE_XOR_OP: w_logic = reg1_i ^ reg2_i;
            EXE_NOR_OP: w_logic = ~(reg1_i | reg2_i);
            default:    w_logic = ZERO_WORD;
        endcase
    end

    always_comb begin
        w_shift = ZERO_WORD;
        case (aluop_i)
            EXE_SLL_OP: w_shift = reg2_i << reg1_i[4:0];
            EXE_SRL_OP: w_shift = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP: w_shift = $signed(reg2_i) >>> reg1_i[4:0];
            default:    w_shift = ZERO_WORD;
        endcase
    end

    always_comb begin
        w_move = ZERO_WORD;
        case (aluop_i)
            EXE_MFHI_OP: w_move = hi_i;
            EXE_MFLO_OP: w_move = lo_i;
            default:     w_move = ZERO_WORD;
        endcase
    end

    // Overflow is judged on the effective (possibly negated) second operand.
    assign w_is_sub   = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
    assign w_reg2_eff = w_is_sub ? (~reg2_i + 32'd1) : reg2_i;
    assign w_sum      = reg1_i + w_reg2_eff;
    assign w_ovf      = (reg1_i[REG_W-1] == w_reg2_eff[REG_W-1]) &&
                        (w_sum[REG_W-1] != reg1_i[REG_W-1]);

    always_comb begin
        w_arith = ZERO_WORD;
        case (aluop_i)
            EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP: w_arith = w_sum;
            EXE_SLT_OP:  w_arith = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: w_arith = {31'd0, reg1_i < reg2_i};
            default:     w_arith = ZERO_WORD;
        endcase
    end

    // Low 64 bits of the product of sign- or zero-extended operands.
    assign w_mul_a   = (aluop_i == EXE_MULT_OP) ? {{REG_W{reg1_i[REG_W-1]}}, reg1_i} : {ZERO_WORD, reg1_i};
    assign w_mul_b   = (aluop_i == EXE_MULT_OP) ? {{REG_W{reg2_i[REG_W-1]}}, reg2_i} : {ZERO_WORD, reg2_i};
    assign w_product = w_mul_a * w_mul_b;

    always_comb begin
        w_wdata = ZERO_WORD;
        case (alusel_i)
            EXE_RES_LOGIC:       w_wdata = w_logic;
            EXE_RES_SHIFT:       w_wdata = w_shift;
            EXE_RES_MOVE:        w_wdata = w_move;
            EXE_RES_ARITHMETIC:  w_wdata = w_arith;
            EXE_RES_MUL:         w_wdata = w_product[REG_W-1:0];
            EXE_RES_JUMP_BRANCH: w_wdata = link_address_i;
            EXE_RES_NOP:         w_wdata = ZERO_WORD;
            default:             w_wdata = ZERO_WORD;
        endcase
    end

`ifdef HW_DIV_EN
    logic               w_div_op;
    logic [2*REG_W-1:0] w_div_result;
    logic               w_div_ready;

    assign w_div_op = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign w_stall  = w_div_op && (w_div_ready == DIV_RESULT_NOT_READY);

    ex_div u_div (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (aluop_i == EXE_DIV_OP),
        .opdata1_i    (reg1_i),
        .opdata2_i    (reg2_i),
        .start_i      (w_div_op),
        .annul_i      (1'b0),
        .result_o     (w_div_result),
        .ready_o      (w_div_ready)
    );
`else
    logic w_unused_clk;
    assign w_unused_clk = clk;
    assign w_stall      = 1'b0;
`endif

    always_comb begin
        w_whilo = 1'b0;
        w_hi    = ZERO_WORD;
        w_lo    = ZERO_WORD;
        case (aluop_i)
            EXE_MULT_OP, EXE_MULTU_OP: begin
                w_whilo = 1'b1;
                w_hi    = w_product[2*REG_W-1:REG_W];
                w_lo    = w_product[REG_W-1:0];
            end
            EXE_MTHI_OP: begin
                w_whilo = 1'b1;
                w_hi    = reg1_i;
                w_lo    = lo_i;
            end
            EXE_MTLO_OP: begin
                w_whilo = 1'b1;
                w_hi    = hi_i;
                w_lo    = reg1_i;
            end
`ifdef HW_DIV_EN
            EXE_DIV_OP, EXE_DIVU_OP: begin
                w_whilo = w_div_ready;
                w_hi    = w_div_result[2*REG_W-1:REG_W];
                w_lo    = w_div_result[REG_W-1:0];
            end
`endif
            default: begin
                w_whilo = 1'b0;
            end
        endcase
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = ((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_SUB_OP)) && w_ovf ? 1'b0 : wreg_i;
        wdata_o    = w_wdata;
        whilo_o    = w_whilo;
        hi_o       = w_hi;
        lo_o       = w_lo;
        stallreq_o = w_stall;
        if (rst) begin
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = ZERO_WORD;
            whilo_o    = 1'b0;
            hi_o       = ZERO_WORD;
            lo_o       = ZERO_WORD;
            stallreq_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for the execute stage: directed vectors push expectations,
// a negedge monitor pops and compares once stallreq_o drops.
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, link_address_i, hi_i, lo_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    ex dut (
        .clk            (clk),
        .rst            (rst),
        .aluop_i        (aluop_i),
        .alusel_i       (alusel_i),
        .reg1_i         (reg1_i),
        .reg2_i         (reg2_i),
        .wd_i           (wd_i),
        .wreg_i         (wreg_i),
        .link_address_i (link_address_i),
        .hi_i           (hi_i),
        .lo_i           (lo_i),
        .wd_o           (wd_o),
        .wreg_o         (wreg_o),
        .wdata_o        (wdata_o),
        .whilo_o        (whilo_o),
        .hi_o           (hi_o),
        .lo_o           (lo_o),
        .stallreq_o     (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
        logic        chk_hilo;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    stall_cnt = 0;
    int    vec_id = 0;
    logic  in_flight = 1'b0;

    localparam logic [31:0] HI_IN   = 32'h1234_5678;
    localparam logic [31:0] LO_IN   = 32'h9ABC_DEF0;
    localparam logic [31:0] LINK_IN = 32'h0040_0008;

    task automatic check(input string nm, input string field, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (in_flight) begin
            if (stallreq_o) begin
                stall_cnt++;
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, "stalls", 64'(stall_cnt), 64'(e.stalls));
                check(nm, "wd",     64'(wd_o),      64'(e.wd));
                check(nm, "wreg",   64'(wreg_o),    64'(e.wreg));
                check(nm, "wdata",  64'(wdata_o),   64'(e.wdata));
                check(nm, "whilo",  64'(whilo_o),   64'(e.whilo));
                if (e.chk_hilo) begin
                    check(nm, "hi", 64'(hi_o), 64'(e.hi));
                    check(nm, "lo", 64'(lo_o), 64'(e.lo));
                end
                in_flight = 1'b0;
            end
        end
    end

    // Called just after a rising edge; returns on the edge that retires the vector.
    task automatic apply(input string nm, input logic r, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input logic wr,
                         input logic ewreg, input logic [31:0] ewdata, input logic ewhilo,
                         input logic [31:0] ehi, input logic [31:0] elo, input int est);
        exp_t e;
        int   guard;
        #1;
        vec_id++;
        rst      = r;
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = 5'(vec_id);
        wreg_i   = wr;
        e.wd       = r ? 5'd0 : 5'(vec_id);
        e.wreg     = ewreg;
        e.wdata    = ewdata;
        e.whilo    = ewhilo;
        e.hi       = ehi;
        e.lo       = elo;
        e.stalls   = est;
        e.chk_hilo = ewhilo || r;
        exp_q.push_back(e);
        name_q.push_back(nm);
        stall_cnt = 0;
        in_flight = 1'b1;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (in_flight && guard < 100);
        if (in_flight) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: no result after %0d cycles, expected one after %0d stalls", nm, guard, est);
            in_flight = 1'b0;
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        aluop_i        = 8'h00;
        alusel_i       = EXE_RES_NOP;
        reg1_i         = '0;
        reg2_i         = '0;
        wd_i           = '0;
        wreg_i         = 1'b0;
        hi_i           = HI_IN;
        lo_i           = LO_IN;
        link_address_i = LINK_IN;
        repeat (2) @(posedge clk);

        apply("reset",  1, EXE_ADD_OP,  EXE_RES_ARITHMETIC, 32'd5, 32'd3, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        apply("and",    0, EXE_AND_OP,  EXE_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 1, 1, 32'hF000F000, 0, 0, 0, 0);
        apply("or",     0, EXE_OR_OP,   EXE_RES_LOGIC, 32'hF0F0F0F0, 32'h0F0F0000, 1, 1, 32'hFFFFF0F0, 0, 0, 0, 0);
        apply("xor",    0, EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 1, 1, 32'hF0F00F0F, 0, 0, 0, 0);
        apply("nor",    0, EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0000FFFF, 32'h00FF0000, 1, 1, 32'hFF000000, 0, 0, 0, 0);
        apply("bad_op", 0, 8'hFF,       EXE_RES_LOGIC, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'h0, 0, 0, 0, 0);
        apply("sll",    0, EXE_SLL_OP,  EXE_RES_SHIFT, 32'h00000024, 32'h0000000F, 1, 1, 32'h000000F0, 0, 0, 0, 0);
        apply("srl",    0, EXE_SRL_OP,  EXE_RES_SHIFT, 32'd8, 32'h80000000, 1, 1, 32'h00800000, 0, 0, 0, 0);
        apply("sra",    0, EXE_SRA_OP,  EXE_RES_SHIFT, 32'd8, 32'h80000000, 1, 1, 32'hFF800000, 0, 0, 0, 0);
        apply("add_ov", 0, EXE_ADD_OP,  EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'h1, 1, 0, 32'h80000000, 0, 0, 0, 0);
        apply("addu",   0, EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'h1, 1, 1, 32'h80000000, 0, 0, 0, 0);
        apply("sub",    0, EXE_SUB_OP,  EXE_RES_ARITHMETIC, 32'd5, 32'd7, 1, 1, 32'hFFFFFFFE, 0, 0, 0, 0);
        apply("sub_ov", 0, EXE_SUB_OP,  EXE_RES_ARITHMETIC, 32'h80000000, 32'h1, 1, 0, 32'h7FFFFFFF, 0, 0, 0, 0);
        apply("subu",   0, EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'h80000000, 32'h1, 1, 1, 32'h7FFFFFFF, 0, 0, 0, 0);
        apply("slt",    0, EXE_SLT_OP,  EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1, 1, 1, 32'h1, 0, 0, 0, 0);
        apply("sltu",   0, EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1, 1, 1, 32'h0, 0, 0, 0, 0);
        apply("mult",   0, EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'h2, 0, 0, 32'h0, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        apply("multu",  0, EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'h2, 0, 0, 32'h0, 1, 32'h00000001, 32'hFFFFFFFE, 0);
        apply("mfhi",   0, EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 1, 1, HI_IN, 0, 0, 0, 0);
        apply("mflo",   0, EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 1, 1, LO_IN, 0, 0, 0, 0);
        apply("mthi",   0, EXE_MTHI_OP, EXE_RES_NOP, 32'hCAFEBABE, 32'h0, 0, 0, 32'h0, 1, 32'hCAFEBABE, LO_IN, 0);
        apply("mtlo",   0, EXE_MTLO_OP, EXE_RES_NOP, 32'hCAFEBABE, 32'h0, 0, 0, 32'h0, 1, HI_IN, 32'hCAFEBABE, 0);
        apply("jal",    0, 8'h50,       EXE_RES_JUMP_BRANCH, 32'h0, 32'h0, 1, 1, LINK_IN, 0, 0, 0, 0);
        apply("nop",    0, 8'h00,       EXE_RES_NOP, 32'h1234, 32'h5678, 0, 0, 32'h0, 0, 0, 0, 0);

`ifdef HW_DIV_EN
        apply("div_m7_2",   0, EXE_DIV_OP,  EXE_RES_NOP, 32'hFFFFFFF9, 32'd2, 0, 0, 32'h0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        apply("after_div",  0, 8'h00,       EXE_RES_NOP, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);
        apply("div_7_m2",   0, EXE_DIV_OP,  EXE_RES_NOP, 32'd7, 32'hFFFFFFFE, 0, 0, 32'h0, 1, 32'h00000001, 32'hFFFFFFFD, 33);
        apply("divu_by0",   0, EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 2);
        apply("divu_10_3a", 0, EXE_DIVU_OP, EXE_RES_NOP, 32'd10, 32'd3, 0, 0, 32'h0, 1, 32'h1, 32'h3, 33);
        apply("divu_10_3b", 0, EXE_DIVU_OP, EXE_RES_NOP, 32'd10, 32'd3, 0, 0, 32'h0, 1, 32'h1, 32'h3, 33);
        // Start a divide, let 15 iterations run, then reset in the middle of it.
        #1;
        rst      = 1'b0;
        aluop_i  = EXE_DIVU_OP;
        alusel_i = EXE_RES_NOP;
        reg1_i   = 32'd1000;
        reg2_i   = 32'd7;
        repeat (16) @(posedge clk);
        apply("rst_mid_div", 1, EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd7, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        apply("divu_9_3",    0, EXE_DIVU_OP, EXE_RES_NOP, 32'd9, 32'd3, 0, 0, 32'h0, 1, 32'h0, 32'h3, 33);
`else
        apply("div_as_nop",  0, EXE_DIV_OP,  EXE_RES_NOP, 32'hFFFFFFF9, 32'd2, 0, 0, 32'h0, 0, 0, 0, 0);
        apply("divu_as_nop", 0, EXE_DIVU_OP, EXE_RES_NOP, 32'd10, 32'd3, 0, 0, 32'h0, 0, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
